// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment driver: latches a full frame once per scan,
// then walks the digits with a dead-time gap, per-digit blink and global blanking.
module seg_scan #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned DEAD         = 2,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] show,
   input  logic [7:0]  blink_mask,
   input  logic        blank,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        frame_start
);

   localparam int unsigned CNT_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       dig_q, dig_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             phase_q, phase_d;
   logic [63:0]      shadow_q, shadow_d;
   logic [7:0]       seg_q, seg_d;
   logic [7:0]       an_q, an_d;
   logic             frame_start_q, frame_start_d;

   logic slot_end;
   logic frame_end;
   logic load;
   logic off;

   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (dig_q == 3'd7);
      load      = (cnt_q == '0) && (dig_q == '0);

      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
      dig_d = slot_end ? dig_q + 3'd1 : dig_q;

      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_end) begin
         if (frame_cnt_q == FRM_LAST) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
         end
      end

      shadow_d      = load ? show : shadow_q;
      frame_start_d = load;

      // Digit 0 reads the shadow while it is being reloaded; dead time hides that cycle.
      off  = (cnt_q < DEAD_C) | blank | (blink_mask[dig_q] & phase_q);
      an_d  = off ? '1 : ~(8'b1 << dig_q);
      seg_d = off ? '1 : shadow_q[{dig_q, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q         <= '0;
         dig_q         <= '0;
         frame_cnt_q   <= '0;
         phase_q       <= 1'b0;
         shadow_q      <= '1;
         seg_q         <= '1;
         an_q          <= '1;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         dig_q         <= dig_d;
         frame_cnt_q   <= frame_cnt_d;
         phase_q       <= phase_d;
         shadow_q      <= shadow_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboarded bench for seg_scan: a timeline model queues the expected pins per edge,
// a monitor pops and compares; a second instance checks the DEAD=2 slot shape.
module tb_seg_scan;

   logic        clk;
   logic        rst;
   logic [63:0] show;
   logic [7:0]  blink_mask;
   logic        blank;
   logic [7:0]  seg, an;
   logic        frame_start;

   logic        rst2;
   logic [63:0] show2;
   logic [7:0]  seg2, an2;
   logic        frame_start2;

   int total = 0;
   int bad   = 0;
   logic done2 = 1'b0;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       fs;
   } exp_t;
   exp_t exp_q[$];

   int          m_t;
   logic [63:0] m_shadow;

   seg_scan #(.REFRESH_DIV(4), .DEAD(1), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .show(show), .blink_mask(blink_mask), .blank(blank),
      .seg(seg), .an(an), .frame_start(frame_start)
   );

   seg_scan #(.REFRESH_DIV(3), .DEAD(2), .BLINK_FRAMES(1)) dut2 (
      .clk(clk), .rst(rst2), .show(show2), .blink_mask(8'h00), .blank(1'b0),
      .seg(seg2), .an(an2), .frame_start(frame_start2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected pins after the coming edge, from absolute time since release.
   task automatic tick();
      exp_t e;
      int cnt, dig, phase;
      logic off;
      if (!rst) begin
         e.an = 8'hFF; e.seg = 8'hFF; e.fs = 1'b0;
         m_t = 0;
         m_shadow = '1;
      end else begin
         cnt   = m_t % 4;
         dig   = (m_t / 4) % 8;
         phase = (m_t / 64) % 2;
         off   = (cnt < 1) || blank || (blink_mask[dig] && (phase == 1));
         e.an  = off ? 8'hFF : ~(8'b1 << dig);
         e.seg = off ? 8'hFF : m_shadow[dig*8 +: 8];
         e.fs  = (m_t % 32 == 0);
         if (m_t % 32 == 0) m_shadow = show;
         m_t++;
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_an",  an,  e.an);
            chk("sb_seg", seg, e.seg);
            chk("sb_fs",  {7'b0, frame_start}, {7'b0, e.fs});
         end
      end
   end

   initial begin : slot_shape
      logic [7:0] exp_an, exp_seg;
      int d;
      rst2  = 1'b0;
      show2 = 64'h7766_5544_3322_1100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst2 = 1'b1;
      for (int u = 0; u < 1200; u++) begin
         @(posedge clk);
         #1;
         d = (u / 3) % 8;
         exp_an  = (u % 3 == 2) ? ~(8'b1 << d) : 8'hFF;
         exp_seg = (u % 3 == 2) ? show2[d*8 +: 8] : 8'hFF;
         chk("d2_an", an2, exp_an);
         chk("d2_seg", seg2, exp_seg);
         chk("d2_onehot", {7'b0, ($countones(~an2) <= 1)}, 8'h01);
      end
      done2 = 1'b1;
   end

   initial begin : driver
      rst        = 1'b0;
      show       = 64'h0123_4567_89AB_CDEF;
      blink_mask = 8'h00;
      blank      = 1'b0;
      m_t        = 0;
      m_shadow   = '1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_an", an, 8'hFF);
         chk("rst_seg", seg, 8'hFF);
      end
      rst = 1'b1;

      for (int t = 0; t < 310; t++) begin
         tick();
         if (t % 4 == 0 && t < 32) begin
            chk("slot0_an", an, 8'hFF);
            chk("slot0_seg", seg, 8'hFF);
         end
         case (t)
            0:   chk("fs_first", {7'b0, frame_start}, 8'h01);
            1:   begin chk("d0_an", an, 8'hFE); chk("d0_seg", seg, 8'hEF); end
            5, 6, 7: begin chk("d1_an", an, 8'hFD); chk("d1_seg", seg, 8'hCD); end
            29:  begin chk("d7_an", an, 8'h7F); chk("d7_seg", seg, 8'h01); end
            44:  show = {8{8'hC0}};
            61:  chk("notear_seg", seg, 8'h01);
            63:  chk("fs_low", {7'b0, frame_start}, 8'h00);
            64:  chk("fs_frame2", {7'b0, frame_start}, 8'h01);
            65:  begin chk("newf_an", an, 8'hFE); chk("newf_seg", seg, 8'hC0); end
            127: blink_mask = 8'h81;
            129: begin chk("blk_lit_an", an, 8'hFE); chk("blk_lit_seg", seg, 8'hC0); end
            193: begin chk("blk_d0_an", an, 8'hFF); chk("blk_d0_seg", seg, 8'hFF); end
            197: chk("blk_d1_an", an, 8'hFD);
            221: chk("blk_d7_an", an, 8'hFF);
            229: chk("blk_d1b_an", an, 8'hFD);
            255: blink_mask = 8'h00;
            265: blank = 1'b1;
            266: begin chk("blank_an", an, 8'hFF); chk("blank_seg", seg, 8'hFF); end
            275: begin chk("blank_end_an", an, 8'hFF); blank = 1'b0; end
            277: begin chk("unblank_an", an, 8'hDF); chk("unblank_seg", seg, 8'hC0); end
            288: chk("fs_blank", {7'b0, frame_start}, 8'h01);
            default: ;
         endcase
      end

      rst  = 1'b0;
      show = 64'hFEDC_BA98_7654_3210;
      tick();
      chk("midrst_an", an, 8'hFF);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_fs", {7'b0, frame_start}, 8'h00);
      rst = 1'b1;
      for (int t = 0; t < 64; t++) begin
         tick();
         case (t)
            0:  chk("re_fs", {7'b0, frame_start}, 8'h01);
            1:  begin chk("re_d0_an", an, 8'hFE); chk("re_d0_seg", seg, 8'h10); end
            29: begin chk("re_d7_an", an, 8'h7F); chk("re_d7_seg", seg, 8'hFE); end
            default: ;
         endcase
      end

      for (int i = 0; i < 5000 && !done2; i++) @(negedge clk);
      chk("d2_done", {7'b0, done2}, 8'h01);
      chk("sb_drained", 8'(exp_q.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
